mp_addsub_seq: RTL and testbench
================================

// Module: mp_addsub_seq
// PURPOSE
//  Multi-precision sequential adder/subtractor. Adds or subtracts two WORDS*N-bit operands one
//  N-bit chunk per clock, LS chunk first, through a single rca_nbit #(.N(N)) instance.
//  A registered carry links the chunks. Sits directly around the ripple-carry stage: it feeds
//  the stage its operand chunks and consumes its Sum/Carry. It trades latency for area on wide words.
// PARAMETERS
//  N      4  chunk width; width of the instantiated rca_nbit
//  WORDS  4  chunks per operand; operand width W = N*WORDS (WORDS >= 2)
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  start      in   1  request; sampled only in IDLE
//  sub        in   1  0 = a+b, 1 = a-b; sampled with start
//  a          in   W  operand A, sampled with start
//  b          in   W  operand B, sampled with start
//  busy       out  1  high in RUN and DONE
//  out_valid  out  1  result/flags valid (DONE state)
//  out_ready  in   1  consumer accepts the result
//  result     out  W  sum/difference
//  carry_out  out  1  final carry (for sub: 1 = no borrow)
//  overflow   out  1  two's-complement signed overflow
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE; busy, out_valid, result, carry_out, overflow all 0.
//    Also clears the chunk index, carry register and operand registers. Takes priority in any state.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE, start=1 at an edge:
//    - latch a; latch b if sub=0, else ~b
//    - carry reg <= sub; idx <= 0; clear result; go to RUN
//  - RUN, each cycle: rca_nbit gets A[idx], B'[idx] and the carry reg.
//    - At the edge: result[idx*N +: N] <= Sum; carry reg <= Carry; idx <= idx+1.
//    - When idx == WORDS-1 at that edge:
//      - carry_out <= Carry
//      - overflow <= Carry ^ (A_msb ^ B'_msb ^ Sum_msb), i.e. carry-out XOR carry-into-MSB
//      - go to DONE
//  - Latency: start sampled at edge E0 -> out_valid high after edge E_WORDS (WORDS cycles).
//  - DONE: out_valid=1; result/flags held stable until out_ready=1 at an edge, then IDLE.
//    - out_valid drops at that same edge.
//    - Minimum start-to-start spacing: WORDS+2 cycles.
//  - start while busy (RUN or DONE) is ignored; no queueing.
//    - start together with out_ready in DONE is also ignored; it must be re-asserted in IDLE.
//  - a, b, sub may change freely after the start edge; internal copies are used.
//  - Arithmetic is modulo 2^W; carries ripple across all chunk boundaries via the carry reg.
//  - Reset mid-RUN or in DONE aborts the operation; start is accepted the cycle after rst falls.
// CONFIGURATION
//  - Macro ADDSUB_SAT_EN defined: signed saturation on the result output while out_valid=1.
//    - Combinational mux, latency unchanged.
//    - If overflow=1 and A_msb=0: result = {1'b0,{W-1{1'b1}}}.
//    - If overflow=1 and A_msb=1: result = {1'b1,{W-1{1'b0}}}.
//    - overflow and carry_out still report the raw (unsaturated) values.
//  - ADDSUB_SAT_EN undefined: result wraps modulo 2^W. No saturation logic is present.
// TESTING (N=4, WORDS=4, W=16)
//  1. add a=16'h1234 b=16'h4321 -> out_valid 4 cycles after start edge; result=16'h5555, carry_out=0, overflow=0
//  2. sub a=16'h0005 b=16'h0007 -> result=16'hFFFE, carry_out=0 (borrow), overflow=0
//  3. add a=16'hFFFF b=16'h0001 -> result=16'h0000, carry_out=1, overflow=0 (carry crosses all 3 chunk boundaries)
//  4. add a=16'h7FFF b=16'h0001 -> overflow=1; result=16'h8000 (wrap) / 16'h7FFF with ADDSUB_SAT_EN;
//     sub a=16'h8000 b=16'h0001 -> overflow=1; result=16'h7FFF / 16'h8000 with ADDSUB_SAT_EN
//  5. out_ready held 0 for 10 cycles in DONE, with start pulsed and a/b changed
//     -> result/flags stable, no new op; out_ready=1 -> IDLE, busy=0 next cycle
//  6. rst=1 for one edge in the 2nd RUN cycle -> all outputs 0, IDLE
//     -> next start a=16'h0001 b=16'h0001 add gives 16'h0002 with normal latency

Source files
------------

// File: rtl/mp_addsub_seq_if.sv
// Handshake/bus interface for mp_addsub_seq.
//   master : requester side; drives start, sub, a, b and out_ready
//   slave  : adder side; drives busy, out_valid, result, carry_out and overflow
// Parameters N and WORDS must match the attached mp_addsub_seq instance (W = N*WORDS).
interface mp_addsub_seq_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WORDS = 4
);
  localparam int unsigned W = N * WORDS;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  modport master (
    output start, sub, a, b, out_ready,
    input  busy, out_valid, result, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b, out_ready,
    output busy, out_valid, result, carry_out, overflow
  );
endinterface

// File: rtl/mp_addsub_seq.sv
// Multi-precision sequential adder/subtractor.
// Adds or subtracts two W = N*WORDS bit operands one N-bit chunk per clock, LS chunk first,
// through a single N-bit ripple-carry stage (rca_nbit). A registered carry links the chunks.
//
// Ports:
//   clk  in  single clock, rising edge
//   rst  in  synchronous, active-high reset
//   bus  mp_addsub_seq_if.slave
//          start/sub/a/b  request, sampled only in IDLE
//          busy           high in RUN and DONE
//          out_valid      result/flags valid (DONE)
//          out_ready      consumer accepts the result
//          result         sum/difference (modulo 2^W)
//          carry_out      final carry (subtract: 1 = no borrow)
//          overflow       two's-complement signed overflow
//
// Optional build macro ADDSUB_SAT_EN: when defined, result is saturated to the signed
// range while out_valid=1 and overflow=1; flags still report raw values.

// N-bit ripple-carry adder stage.
module rca_nbit #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         carry
);
  logic [N:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    carry = c[N];
  end
endmodule

module mp_addsub_seq #(
  parameter int unsigned N     = 4,
  parameter int unsigned WORDS = 4
) (
  input logic           clk,
  input logic           rst,
  mp_addsub_seq_if.slave bus
);
  localparam int unsigned W    = N * WORDS;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state;
  logic [IdxW-1:0] idx;
  logic            carry;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;   // already inverted for subtract
  logic [W-1:0]    res;
  logic            cout;
  logic            ovf;
  logic            busy;
  logic            valid;

  logic [N-1:0] chunk_a;
  logic [N-1:0] chunk_b;
  logic [N-1:0] chunk_sum;
  logic         chunk_carry;

  assign chunk_a = op_a[idx*N +: N];
  assign chunk_b = op_b[idx*N +: N];

  rca_nbit #(
    .N(N)
  ) u_rca (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry),
    .sum  (chunk_sum),
    .carry(chunk_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= StIdle;
      idx   <= '0;
      carry <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.start) begin
            op_a  <= bus.a;
            op_b  <= bus.sub ? ~bus.b : bus.b;
            // Subtract is a + ~b + 1: the +1 enters as the first chunk's carry-in.
            carry <= bus.sub;
            idx   <= '0;
            res   <= '0;
            busy  <= 1'b1;
            state <= StRun;
          end
        end
        StRun: begin
          res[idx*N +: N] <= chunk_sum;
          carry           <= chunk_carry;
          idx             <= idx + 1'b1;
          if (idx == LastIdx) begin
            cout  <= chunk_carry;
            // Carry into the MSB recovered from the MSB sum bit; XOR with carry-out.
            ovf   <= chunk_carry ^ (chunk_a[N-1] ^ chunk_b[N-1] ^ chunk_sum[N-1]);
            valid <= 1'b1;
            state <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.out_valid = valid;
  assign bus.carry_out = cout;
  assign bus.overflow  = ovf;

`ifdef ADDSUB_SAT_EN
  always_comb begin
    bus.result = res;
    if (valid && ovf) begin
      bus.result = op_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign bus.result = res;
`endif
endmodule

// File: tb/tb_mp_addsub_seq.sv
// Self-checking bench for mp_addsub_seq (N=4, WORDS=4, W=16).
module tb_mp_addsub_seq;
  localparam int unsigned N     = 4;
  localparam int unsigned WORDS = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mp_addsub_seq_if #(.N(N), .WORDS(WORDS)) bus ();

  mp_addsub_seq #(
    .N    (N),
    .WORDS(WORDS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full-width operands.
  task automatic model(input logic [15:0] x, input logic [15:0] y, input logic s,
                       output logic [15:0] r, output logic c, output logic v);
    int ux, uy, sx, sy, sr;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      r  = 16'((ux - uy) & 32'hFFFF);
      c  = (ux >= uy);
      sr = sx - sy;
    end else begin
      r  = 16'((ux + uy) & 32'hFFFF);
      c  = ((ux + uy) > 65535);
      sr = sx + sy;
    end
    v = (sr > 32767) || (sr < -32768);
`ifdef ADDSUB_SAT_EN
    if (v) r = x[15] ? 16'h8000 : 16'h7FFF;
`endif
  endtask

  // Issue one operation and check latency, result and flags. Leaves the DUT in DONE.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                        input string tag);
    logic [15:0] er;
    logic        ec, ev;
    int          cyc;
    model(x, y, s, er, ec, ev);
    bus.a     = x;
    bus.b     = y;
    bus.sub   = s;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    // Scramble inputs: the DUT must work from its own copies.
    bus.a     = 16'($urandom);
    bus.b     = 16'($urandom);
    bus.sub   = ~s;
    chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, ".lat"}, 32'(cyc), 32'(WORDS));
    chk({tag, ".res"}, 32'(bus.result), 32'(er));
    chk({tag, ".cout"}, 32'(bus.carry_out), 32'(ec));
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(ev));
  endtask

  task automatic release_op(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, ".vld0"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".busy0"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [15:0] held_res;
    logic        held_c, held_v;
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.sub       = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.vld", 32'(bus.out_valid), 32'd0);
    chk("rst.res", 32'(bus.result), 32'd0);
    chk("rst.cout", 32'(bus.carry_out), 32'd0);
    chk("rst.ovf", 32'(bus.overflow), 32'd0);

    // Directed cases.
    run_op(16'h1234, 16'h4321, 1'b0, "add1");
    release_op("add1");
    run_op(16'h0005, 16'h0007, 1'b1, "sub2");
    release_op("sub2");
    run_op(16'hFFFF, 16'h0001, 1'b0, "add3");
    release_op("add3");
    run_op(16'h7FFF, 16'h0001, 1'b0, "ovf4a");
    release_op("ovf4a");
    run_op(16'h8000, 16'h0001, 1'b1, "ovf4b");
    release_op("ovf4b");
    run_op(16'h8000, 16'h8000, 1'b0, "ovf4c");
    release_op("ovf4c");

    // Hold in DONE with start pulses and changing operands.
    run_op(16'hA5A5, 16'h0F0F, 1'b1, "hold5");
    held_res = bus.result;
    held_c   = bus.carry_out;
    held_v   = bus.overflow;
    for (int i = 0; i < 10; i++) begin
      bus.start = i[0];
      bus.a     = 16'($urandom);
      bus.b     = 16'($urandom);
      bus.sub   = i[1];
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    chk("hold5.vld", 32'(bus.out_valid), 32'd1);
    chk("hold5.res", 32'(bus.result), 32'(held_res));
    chk("hold5.cout", 32'(bus.carry_out), 32'(held_c));
    chk("hold5.ovf", 32'(bus.overflow), 32'(held_v));
    // start together with out_ready is dropped.
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    chk("hold5.vld0", 32'(bus.out_valid), 32'd0);
    chk("hold5.busy0", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    chk("hold5.nostart", 32'(bus.busy), 32'd0);

    // Reset during the second RUN cycle.
    bus.a     = 16'h1111;
    bus.b     = 16'h2222;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst6.busy", 32'(bus.busy), 32'd0);
    chk("rst6.vld", 32'(bus.out_valid), 32'd0);
    chk("rst6.res", 32'(bus.result), 32'd0);
    chk("rst6.cout", 32'(bus.carry_out), 32'd0);
    chk("rst6.ovf", 32'(bus.overflow), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, "rst6.op");
    release_op("rst6.op");

    // Random operations.
    for (int i = 0; i < 24; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
      release_op($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
